// File: rtl/tt_um_logarithmic_afpm.sv
// -----------------------------------------------------------------------------
// tt_um_logarithmic_afpm
//   Approximate FP16 (binary16) multiplier based on Mitchell's logarithmic
//   approximation. Operands arrive byte-serially (low byte first) on ui_in (A)
//   and uio_in (B) in a fixed frame of 2*BYTE_CYCLES clocks. The product is
//   registered at the end of the frame and shown on uo_out during the next
//   frame: low byte for the first BYTE_CYCLES clocks, high byte for the rest.
//
//   Build option: define LOG_CORR_EN to add the partial-product correction
//   term ma[9:5]*mb[9:5] when the fraction sum does not carry.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   ena      in   design select (ignored)
//   ui_in    in   [7:0] operand A byte
//   uio_in   in   [7:0] operand B byte
//   uo_out   out  [7:0] result byte
//   uio_out  out  [7:0] tied 0
//   uio_oe   out  [7:0] tied 0 (uio pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_logarithmic_afpm #(
  parameter int BYTE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int FRAME = 2 * BYTE_CYCLES;
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LO_LAST = CW'(BYTE_CYCLES - 1);
  localparam logic [CW-1:0] HI_LAST = CW'(FRAME - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    a_lo_q, a_lo_d;
  logic [7:0]    b_lo_q, b_lo_d;
  logic [15:0]   result_q, result_d;

  // ena carries no meaning for this block
  logic unused_ena;
  assign unused_ena = ena;

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // ---------------------------------------------------------------------------
  // Multiplier datapath (combinational on the full operands at high-byte time)
  // ---------------------------------------------------------------------------
  logic [15:0]        op_a, op_b, prod;
  logic [4:0]         ea, eb;
  logic [9:0]         ma, mb;
  logic               sgn;
  logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic signed [16:0] s;
`ifdef LOG_CORR_EN
  logic [9:0]         corr;
`endif

  assign op_a = {ui_in,  a_lo_q};
  assign op_b = {uio_in, b_lo_q};

  always_comb begin
    ea     = op_a[14:10];
    eb     = op_b[14:10];
    ma     = op_a[9:0];
    mb     = op_b[9:0];
    sgn    = op_a[15] ^ op_b[15];
    nan_a  = (ea == 5'd31) && (ma != 10'd0);
    nan_b  = (eb == 5'd31) && (mb != 10'd0);
    inf_a  = (ea == 5'd31) && (ma == 10'd0);
    inf_b  = (eb == 5'd31) && (mb == 10'd0);
    // subnormals are flushed, so any zero exponent counts as zero
    zero_a = (ea == 5'd0);
    zero_b = (eb == 5'd0);

    // Log-domain add: exponent/fraction fields added as one fixed-point
    // number, minus the bias (15 << 10).
    s = $signed({2'b00, op_a[14:0]}) + $signed({2'b00, op_b[14:0]}) - 17'sh3C00;
`ifdef LOG_CORR_EN
    corr = 10'(ma[9:5]) * 10'(mb[9:5]);
    // correction only applies when the fraction sum stays below 1.0
    if (({1'b0, ma} + {1'b0, mb}) < 11'd1024)
      s = s + $signed({7'b0, corr});
`endif

    if (nan_a || nan_b)
      prod = 16'h7E00;
    else if ((inf_a && zero_b) || (inf_b && zero_a))
      prod = 16'h7E00;
    else if (inf_a || inf_b)
      prod = {sgn, 15'h7C00};
    else if (zero_a || zero_b)
      prod = {sgn, 15'h0000};
    else if (s <= 17'sh003FF)
      prod = {sgn, 15'h0000};          // underflow: exponent <= 0
    else if (s >= 17'sh07C00)
      prod = {sgn, 15'h7C00};          // overflow to Inf
    else
      prod = {sgn, s[14:0]};
  end

  // ---------------------------------------------------------------------------
  // Frame sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = (cnt_q == HI_LAST) ? '0 : cnt_q + 1'b1;
    a_lo_d   = a_lo_q;
    b_lo_d   = b_lo_q;
    result_d = result_q;
    if (cnt_q == LO_LAST) begin
      a_lo_d = ui_in;
      b_lo_d = uio_in;
    end
    if (cnt_q == HI_LAST)
      result_d = prod;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_lo_q   <= 8'h00;
      b_lo_q   <= 8'h00;
      result_q <= 16'h0000;
    end else begin
      cnt_q    <= cnt_d;
      a_lo_q   <= a_lo_d;
      b_lo_q   <= b_lo_d;
      result_q <= result_d;
    end
  end

  assign uo_out = (cnt_q < CW'(BYTE_CYCLES)) ? result_q[7:0] : result_q[15:8];

endmodule

// File: tb/tb_tt_um_logarithmic_afpm.sv
// -----------------------------------------------------------------------------
// tb_tt_um_logarithmic_afpm
//   Directed frames with hand-computed products. Each frame drives one operand
//   pair and collects the bytes shown on uo_out, which belong to the previous
//   frame's product. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tt_um_logarithmic_afpm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tt_um_logarithmic_afpm #(.BYTE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with cnt==0; returns at the same point
  // of the next frame. obs holds the bytes shown during this frame.
  task automatic frame(input logic [15:0] a, input logic [15:0] b, output logic [15:0] obs);
    ui_in  = a[7:0];
    uio_in = b[7:0];
    obs[7:0] = uo_out;
    @(negedge clk);
    @(negedge clk);
    ui_in  = a[15:8];
    uio_in = b[15:8];
    obs[15:8] = uo_out;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [15:0] o;

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_uo_out", {8'h00, uo_out}, 16'h0000);
    chk("uio_tied", {uio_oe, uio_out}, 16'h0000);
    rst_n = 1'b1;

    frame(16'h0000, 16'h0001, o); chk("after_reset",   o, 16'h0000);
    frame(16'h3E00, 16'h4200, o); chk("zero_subnorm",  o, 16'h0000);
    frame(16'h3D00, 16'h3D00, o); chk("1.5x3.0",       o, 16'h4400);
    frame(16'h7C00, 16'hC000, o);
`ifdef LOG_CORR_EN
    chk("1.25x1.25", o, 16'h3E40);
`else
    chk("1.25x1.25", o, 16'h3E00);
`endif
    frame(16'h7C00, 16'h0000, o); chk("inf_x_neg",     o, 16'hFC00);
    frame(16'h7BFF, 16'h7BFF, o); chk("inf_x_zero",    o, 16'h7E00);
    frame(16'h0400, 16'h0400, o); chk("overflow",      o, 16'h7C00);
    frame(16'h7E01, 16'h3C00, o); chk("underflow",     o, 16'h0000);
    frame(16'hBC00, 16'h3C00, o); chk("nan",           o, 16'h7E00);
    frame(16'h3C00, 16'h8000, o); chk("neg_one",       o, 16'hBC00);
    frame(16'h0400, 16'h3C00, o); chk("neg_zero",      o, 16'h8000);
    frame(16'h0400, 16'h3BFF, o); chk("min_normal",    o, 16'h0400);
    frame(16'h7BFF, 16'h3C00, o); chk("s_eq_3ff",      o, 16'h0000);
    frame(16'h3C00, 16'h3C00, o); chk("max_normal",    o, 16'h7BFF);

    // Mid-frame reset: low bytes captured, then reset before the high byte.
    ui_in  = 8'h55;
    uio_in = 8'h66;
    @(negedge clk);
    @(negedge clk);
    ui_in  = 8'h3C;
    uio_in = 8'h3C;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("midreset_uo", {8'h00, uo_out}, 16'h0000);
    rst_n = 1'b1;
    frame(16'h4000, 16'h4000, o); chk("midreset_result", o, 16'h0000);
    frame(16'h0000, 16'h0000, o); chk("post_reset_2x2",  o, 16'h4400);
    frame(16'h0000, 16'h0000, o); chk("zero_again",      o, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
